alu32_responder: RTL and testbench

ALU32_RESPONDER -- requirements
Module: alu32_responder

---
 rtl/alu32_pkg.sv | 29 ++
 rtl/alu32_responder_if.sv | 29 ++
 rtl/alu32_shift_step.sv | 32 +++
 rtl/alu32_responder.sv | 114 +++++++++++
 tb/tb_alu32_responder.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/alu32_pkg.sv
// Shared opcodes, FSM encoding and width for the alu32 responder.
// Imported by the interface, the shift step and the top.
package alu32_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        OP_AND   = 3'b000,
        OP_OR    = 3'b001,
        OP_XOR   = 3'b010,
        OP_NOT   = 3'b011,
        OP_ADD   = 3'b100,
        OP_LSH   = 3'b101,
        OP_RSH   = 3'b110,
        OP_TRUNC = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    // Keeps bits [n-1:0]; n = 0 yields an all-zero mask.
    function automatic logic [DATA_W-1:0] trunc_mask(input logic [4:0] n);
        return (32'h1 << n) - 32'h1;
    endfunction

endpackage

// File: rtl/alu32_responder_if.sv
// Request/response bundle of the alu32 responder.
// master: requester/consumer side; slave: the responder.
interface alu32_responder_if;
    import alu32_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_op;
    logic [DATA_W-1:0] req_in1;
    logic [DATA_W-1:0] req_in2;
    logic              req_ci;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_co;
    logic [2:0]        rsp_op;
    logic              busy;

    modport master (
        output req_valid, req_op, req_in1, req_in2, req_ci, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_co, rsp_op, busy
    );

    modport slave (
        input  req_valid, req_op, req_in1, req_in2, req_ci, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_co, rsp_op, busy
    );

endinterface

// File: rtl/alu32_shift_step.sv
// One logical shift step of up to SHIFT_STEP bits (combinational).
// Ports: val_i/left_i/rem_i in; shifted val_o, remaining rem_o, last bit out_o.
module alu32_shift_step
    import alu32_pkg::*;
#(
    parameter int SHIFT_STEP = 1
) (
    input  logic [DATA_W-1:0] val_i,
    input  logic              left_i,
    input  logic [4:0]        rem_i,
    output logic [DATA_W-1:0] val_o,
    output logic [4:0]        rem_o,
    output logic              out_o
);

    localparam logic [4:0] STEP = 5'(SHIFT_STEP);

    logic [4:0] k;

    always_comb begin
        // Final step only moves what is left of the count.
        k     = (rem_i < STEP) ? rem_i : STEP;
        rem_o = rem_i - k;
        val_o = left_i ? (val_i << k) : (val_i >> k);
        out_o = 1'b0;
        if (k != 5'd0) begin
            // Last bit to leave: bit 32-k going left, bit k-1 going right.
            out_o = left_i ? val_i[5'd0 - k] : val_i[k - 5'd1];
        end
    end

endmodule

// File: rtl/alu32_responder.sv
// 32-bit ALU behind a valid/ready request and response handshake.
// Ports: clk, rst_n (async low), bus (slave side of alu32_responder_if).
module alu32_responder
    import alu32_pkg::*;
#(
    parameter int SHIFT_STEP = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    alu32_responder_if.slave   bus
);

    state_e            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              co_q, co_d;
    logic [4:0]        cnt_q, cnt_d;

    logic              hs;
    logic [4:0]        amt;
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] step_val;
    logic [4:0]        step_rem;
    logic              step_out;

    assign hs  = bus.req_valid && (state_q == ST_IDLE);
    assign amt = bus.req_in2[4:0];
    assign sum = {1'b0, bus.req_in1} + {1'b0, bus.req_in2}
               + {{DATA_W{1'b0}}, bus.req_ci};

    // res_q doubles as the shift working register.
    alu32_shift_step #(
        .SHIFT_STEP (SHIFT_STEP)
    ) u_step (
        .val_i  (res_q),
        .left_i (op_q == OP_LSH),
        .rem_i  (cnt_q),
        .val_o  (step_val),
        .rem_o  (step_rem),
        .out_o  (step_out)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        res_d   = res_q;
        co_d    = co_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (hs) begin
                    op_d    = bus.req_op;
                    co_d    = 1'b0;
                    cnt_d   = 5'd0;
                    state_d = ST_RESP;
                    unique case (op_e'(bus.req_op))
                        OP_AND:   res_d = bus.req_in1 & bus.req_in2;
                        OP_OR:    res_d = bus.req_in1 | bus.req_in2;
                        OP_XOR:   res_d = bus.req_in1 ^ bus.req_in2;
                        OP_NOT:   res_d = ~bus.req_in1;
                        OP_ADD:   {co_d, res_d} = sum;
                        OP_LSH, OP_RSH: begin
                            res_d = bus.req_in1;
                            cnt_d = amt;
                            if (amt != 5'd0) begin
                                state_d = ST_SHIFT;
                            end
                        end
                        OP_TRUNC: res_d = bus.req_in1 & trunc_mask(amt);
                        default:  res_d = res_q;
                    endcase
                end
            end
            ST_SHIFT: begin
                res_d = step_val;
                cnt_d = step_rem;
                co_d  = step_out;
                if (step_rem == 5'd0) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= 3'b000;
            res_q   <= '0;
            co_q    <= 1'b0;
            cnt_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            res_q   <= res_d;
            co_q    <= co_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.req_ready  = (state_q == ST_IDLE);
    assign bus.rsp_valid  = (state_q == ST_RESP);
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.rsp_result = res_q;
    assign bus.rsp_co     = co_q;
    assign bus.rsp_op     = op_q;

endmodule

// File: tb/tb_alu32_responder.sv
// Directed-vector bench for alu32_responder (SHIFT_STEP = 1).
// Expected values are hand-computed constants.
module tb_alu32_responder;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    alu32_responder_if bus ();

    alu32_responder #(
        .SHIFT_STEP (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".ready"}, 32'(bus.req_ready), 32'd1);
        chk({tag, ".valid"}, 32'(bus.rsp_valid), 32'd0);
        chk({tag, ".busy"}, 32'(bus.busy), 32'd0);
    endtask

    // Issue one request, check latency and response, optionally hold
    // rsp_ready low for `hold` cycles, then complete the handshake.
    task automatic do_op(input string tag, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic ci, input logic [31:0] exp_res,
                         input logic exp_co, input int exp_lat,
                         input int hold);
        int lat;
        @(negedge clk);
        chk({tag, ".rdy"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_in1   = a;
        bus.req_in2   = b;
        bus.req_ci    = ci;
        bus.rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        // Scramble inputs and raise rsp_ready early; neither may matter.
        bus.req_valid = 1'b0;
        bus.req_op    = ~op;
        bus.req_in1   = ~a;
        bus.req_in2   = ~b;
        bus.req_ci    = ~ci;
        bus.rsp_ready = 1'b1;
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (bus.rsp_valid) break;
        end
        bus.rsp_ready = 1'b0;
        if (!bus.rsp_valid) begin
            chk({tag, ".timeout"}, 32'(bus.rsp_valid), 32'd1);
            return;
        end
        chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, ".res"}, bus.rsp_result, exp_res);
        chk({tag, ".co"}, 32'(bus.rsp_co), 32'(exp_co));
        chk({tag, ".op"}, 32'(bus.rsp_op), 32'(op));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, ".hv"}, 32'(bus.rsp_valid), 32'd1);
            chk({tag, ".hr"}, 32'(bus.req_ready), 32'd0);
            chk({tag, ".hres"}, bus.rsp_result, exp_res);
            chk({tag, ".hco"}, 32'(bus.rsp_co), 32'(exp_co));
            chk({tag, ".hop"}, 32'(bus.rsp_op), 32'(op));
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        chk_idle({tag, ".end"});
    endtask

    initial begin
        int seen;
        n_cmp = 0;
        n_bad = 0;
        bus.req_valid = 1'b0;
        bus.req_op    = 3'b000;
        bus.req_in1   = '0;
        bus.req_in2   = '0;
        bus.req_ci    = 1'b0;
        bus.rsp_ready = 1'b0;
        rst_n = 1'b0;
        #12;
        chk_idle("rst");
        chk("rst.res", bus.rsp_result, 32'h0);
        chk("rst.co", 32'(bus.rsp_co), 32'd0);
        chk("rst.op", 32'(bus.rsp_op), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // First request handshakes on the first edge after release.
        do_op("and", 3'b000, 32'hF0F0F0F0, 32'h0FF00FF0, 1'b1,
              32'h00F000F0, 1'b0, 1, 0);
        do_op("or", 3'b001, 32'h12340000, 32'h00005678, 1'b0,
              32'h12345678, 1'b0, 1, 0);
        do_op("xor", 3'b010, 32'hFFFF0000, 32'h0F0F0F0F, 1'b0,
              32'hF0F00F0F, 1'b0, 1, 0);
        do_op("not", 3'b011, 32'h0000FFFF, 32'h12345678, 1'b1,
              32'hFFFF0000, 1'b0, 1, 0);
        do_op("add1", 3'b100, 32'hFFFFFFFF, 32'h00000001, 1'b0,
              32'h00000000, 1'b1, 1, 0);
        do_op("add2", 3'b100, 32'h7FFFFFFF, 32'h00000000, 1'b1,
              32'h80000000, 1'b0, 1, 0);
        do_op("lsh1", 3'b101, 32'h80000001, 32'h00000001, 1'b0,
              32'h00000002, 1'b1, 2, 0);
        do_op("rsh31", 3'b110, 32'h00000003, 32'h0000001F, 1'b0,
              32'h00000000, 1'b0, 32, 0);
        do_op("rsh2", 3'b110, 32'h00000006, 32'hFFFFFFE2, 1'b0,
              32'h00000001, 1'b1, 3, 0);
        do_op("lsh0", 3'b101, 32'h12345678, 32'hFFFFFFE0, 1'b0,
              32'h12345678, 1'b0, 1, 0);
        do_op("trc8", 3'b111, 32'hDEADBEEF, 32'hFFFFFFE8, 1'b0,
              32'h000000EF, 1'b0, 1, 0);
        do_op("trc0", 3'b111, 32'hDEADBEEF, 32'h00000000, 1'b0,
              32'h00000000, 1'b0, 1, 0);
        do_op("bp", 3'b100, 32'h00000001, 32'h00000002, 1'b1,
              32'h00000004, 1'b0, 1, 5);

        // Reset in the middle of a 20-bit shift.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = 3'b110;
        bus.req_in1   = 32'hFFFF0000;
        bus.req_in2   = 32'd20;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("mid.busy", 32'(bus.busy), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_idle("mid.rst");
        chk("mid.res", bus.rsp_result, 32'h0);
        chk("mid.op", 32'(bus.rsp_op), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (bus.rsp_valid || bus.busy) seen++;
        end
        bus.rsp_ready = 1'b0;
        chk("mid.norsp", 32'(seen), 32'd0);
        do_op("post", 3'b101, 32'h00000001, 32'h00000004, 1'b0,
              32'h00000010, 1'b0, 5, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
